// File: rtl/mac_pkt_buf.sv
// mac_pkt_buf: single-clock RX frame buffer. Validates frame length and error
// status, commits good frames to a circular word RAM with a length-descriptor
// queue, rolls back bad frames, and presents committed frames to a prefetching
// reader with word-by-word consumption and early discard.
module mac_pkt_buf #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 9,
  parameter int unsigned DESC_DEPTH = 4,
  parameter int unsigned LEN_W      = 11,
  parameter int unsigned MIN_LEN    = 60,
  parameter int unsigned MAX_LEN    = 1518
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        en,
  input  logic                        in_valid,
  input  logic [DATA_W-1:0]           in_data,
  input  logic [$clog2(DATA_W/8):0]   in_bytes,
  input  logic                        in_last,
  input  logic                        in_err,
  output logic                        out_len_valid,
  output logic [LEN_W-1:0]            out_len,
  output logic                        out_data_valid,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        out_rd,
  input  logic                        out_discard,
  output logic [$clog2(DESC_DEPTH):0] frame_cnt,
  output logic [15:0]                 drop_cnt,
  output logic [ADDR_W:0]             level
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned SH    = $clog2(BYTES);
  localparam int unsigned PW    = ADDR_W + 1;
  localparam int unsigned SW    = LEN_W + 1;
  localparam int unsigned DAW   = $clog2(DESC_DEPTH);
  localparam int unsigned CW    = DAW + 1;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  // Storage
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] ram_q;
  logic [LEN_W-1:0]  desc_q [DESC_DEPTH];
  logic [DAW-1:0]    dq_wr, dq_rd;

  // Write-side state
  logic [PW-1:0]     wptr, wptr_head;
  logic [LEN_W-1:0]  len_acc;
  logic              err;
  logic              mid_frame, frame_en;

  // Read-side state
  logic [PW-1:0]     rptr, tail;
  logic [LEN_W-1:0]  words_left;
  logic              fetch_pend;

  // Combinational decode
  logic              frame_on_c, acc_c, wr_beat_c, full_c, wr_ok_c, over_c;
  logic              err_now_c, last_c, desc_full_c, len_ok_c, commit_c, rollback_c;
  logic [SW-1:0]     sum_c;
  logic [PW-1:0]     wptr_nxt, rptr_nxt;
  logic              pop_c, disc_c, rd_c, fetch_c;
  logic [LEN_W-1:0]  pop_len_c;
  logic [SW-1:0]     pop_words_c;

  // Beat acceptance, frame validation and pointer next-state
  always_comb begin
    frame_on_c  = mid_frame ? frame_en : en;
    acc_c       = in_valid && frame_on_c;
    wr_beat_c   = acc_c && (in_bytes != '0);
    full_c      = (level == PW'(DEPTH));
    wr_ok_c     = wr_beat_c && !full_c;
    sum_c       = SW'(len_acc) + SW'(in_bytes);
    over_c      = (sum_c > SW'(MAX_LEN));
    err_now_c   = err || (acc_c && in_err) || (wr_beat_c && full_c) || (acc_c && over_c);
    last_c      = acc_c && in_last;
    desc_full_c = (frame_cnt == CW'(DESC_DEPTH));
    len_ok_c    = (sum_c >= SW'(MIN_LEN)) && (sum_c <= SW'(MAX_LEN));
    commit_c    = last_c && !err_now_c && len_ok_c && !desc_full_c;
    rollback_c  = last_c && !commit_c;

    wptr_nxt = wptr;
    if (rollback_c) begin
      wptr_nxt = wptr_head;
    end else if (wr_ok_c) begin
      wptr_nxt = wptr + PW'(1);
    end

    pop_c       = !out_len_valid && (frame_cnt != '0);
    pop_len_c   = desc_q[dq_rd];
    pop_words_c = (SW'(pop_len_c) + SW'(BYTES - 1)) >> SH;
    disc_c      = out_discard && out_len_valid;
    rd_c        = out_rd && out_data_valid && !disc_c;
    fetch_c     = out_len_valid && !disc_c && !fetch_pend && (words_left != '0) &&
                  (!out_data_valid || rd_c);

    rptr_nxt = rptr;
    if (disc_c) begin
      rptr_nxt = tail;
    end else if (fetch_c) begin
      rptr_nxt = rptr + PW'(1);
    end
  end

  // Word RAM: write port from the receive side, registered read for prefetch
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      mem[wptr[ADDR_W-1:0]] <= in_data;
    end
    if (fetch_c) begin
      ram_q <= mem[rptr[ADDR_W-1:0]];
    end
  end

  // Receive side: frame tracking, length/error accumulation, commit or rollback
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wptr      <= '0;
      wptr_head <= '0;
      len_acc   <= '0;
      err       <= 1'b0;
      mid_frame <= 1'b0;
      frame_en  <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      wptr <= wptr_nxt;
      if (commit_c) begin
        wptr_head <= wptr_nxt;
      end
      if (in_valid) begin
        if (!mid_frame) begin
          frame_en <= en;
        end
        mid_frame <= !in_last;
      end
      if (last_c) begin
        len_acc <= '0;
        err     <= 1'b0;
      end else if (acc_c) begin
        len_acc <= LEN_W'(sum_c);
        err     <= err_now_c;
      end
      if (rollback_c && (drop_cnt != 16'hffff)) begin
        drop_cnt <= drop_cnt + 16'd1;
      end
    end
  end

  // Descriptor queue of committed frame lengths
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dq_wr     <= '0;
      dq_rd     <= '0;
      frame_cnt <= '0;
      for (int i = 0; i < int'(DESC_DEPTH); i++) begin
        desc_q[i] <= '0;
      end
    end else begin
      if (commit_c) begin
        desc_q[dq_wr] <= LEN_W'(sum_c);
        dq_wr         <= dq_wr + DAW'(1);
      end
      if (pop_c) begin
        dq_rd <= dq_rd + DAW'(1);
      end
      case ({commit_c, pop_c})
        2'b10:   frame_cnt <= frame_cnt + CW'(1);
        2'b01:   frame_cnt <= frame_cnt - CW'(1);
        default: frame_cnt <= frame_cnt;
      endcase
    end
  end

  // Reader: frame presentation, prefetch, consumption and discard
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rptr           <= '0;
      tail           <= '0;
      words_left     <= '0;
      fetch_pend     <= 1'b0;
      out_len_valid  <= 1'b0;
      out_len        <= '0;
      out_data_valid <= 1'b0;
      out_data       <= '0;
    end else begin
      rptr <= rptr_nxt;
      if (disc_c) begin
        out_len_valid  <= 1'b0;
        out_data_valid <= 1'b0;
        out_len        <= '0;
        words_left     <= '0;
        fetch_pend     <= 1'b0;
      end else begin
        fetch_pend <= fetch_c;
        if (pop_c) begin
          out_len_valid <= 1'b1;
          out_len       <= pop_len_c;
          words_left    <= LEN_W'(pop_words_c);
          tail          <= rptr + PW'(pop_words_c);
        end
        if (fetch_c) begin
          words_left <= words_left - LEN_W'(1);
        end
        if (fetch_pend) begin
          out_data       <= ram_q;
          out_data_valid <= 1'b1;
        end else if (rd_c) begin
          out_data_valid <= 1'b0;
          out_len        <= (out_len < LEN_W'(BYTES)) ? '0 : out_len - LEN_W'(BYTES);
          if (words_left == '0) begin
            out_len_valid <= 1'b0;
          end
        end
      end
    end
  end

  // Occupancy including words of the frame still being received
  always_ff @(posedge clk) begin
    if (!rstn) begin
      level <= '0;
    end else begin
      level <= wptr_nxt - rptr_nxt;
    end
  end

endmodule
